// File: rtl/bitmanip_exec_pipe_pkg.sv
// Shared definitions for the bitmanip execution pipe: op codes, legality
// check and the two pipeline stage payloads.
package bmu_pkg;

  localparam int BMU_ROB_W = 6;
  localparam int BMU_PRF_W = 6;

  localparam logic [3:0] BMU_AND  = 4'b0000;
  localparam logic [3:0] BMU_OR   = 4'b0001;
  localparam logic [3:0] BMU_XOR  = 4'b0010;
  localparam logic [3:0] BMU_ORCB = 4'b0011;
  localparam logic [3:0] BMU_ANDN = 4'b0100;
  localparam logic [3:0] BMU_ORN  = 4'b0101;
  localparam logic [3:0] BMU_XNOR = 4'b0110;
  localparam logic [3:0] BMU_CTZ  = 4'b1000;
  localparam logic [3:0] BMU_REV8 = 4'b1010;
  localparam logic [3:0] BMU_CPOP = 4'b1011;
  localparam logic [3:0] BMU_CLZ  = 4'b1100;

  // Codes 0111, 1001 and 1101..1111 are unassigned.
  function automatic logic bmu_op_legal(input logic [3:0] op);
    case (op)
      4'b0111, 4'b1001, 4'b1101, 4'b1110, 4'b1111: return 1'b0;
      default:                                     return 1'b1;
    endcase
  endfunction

  typedef struct packed {
    logic [3:0]           op;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [BMU_ROB_W-1:0] rob;
    logic [BMU_PRF_W-1:0] dest;
    logic                 wren;
  } bmu_s1_t;

  typedef struct packed {
    logic [31:0]          result;
    logic [BMU_ROB_W-1:0] rob;
    logic [BMU_PRF_W-1:0] dest;
    logic                 wren;
    logic                 illegal;
  } bmu_s2_t;

endpackage

// File: rtl/bitmanip_exec_pipe_if.sv
// Issue and writeback handshakes of the bitmanip pipe. Signal suffixes are
// relative to the pipe: the slave modport is the pipe, master is its peer.
interface bitmanip_exec_pipe_if #(
  parameter int ROB_W = 6,
  parameter int PRF_W = 6
);
  logic             issue_valid_i;
  logic             issue_ready_o;
  logic [3:0]       issue_op_i;
  logic [31:0]      issue_a_i;
  logic [31:0]      issue_b_i;
  logic [ROB_W-1:0] issue_rob_i;
  logic [PRF_W-1:0] issue_dest_i;
  logic             issue_wren_i;

  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [31:0]      wb_result_o;
  logic [ROB_W-1:0] wb_rob_o;
  logic [PRF_W-1:0] wb_dest_o;
  logic             wb_wren_o;
  logic             wb_illegal_o;

  modport slave (
    input  issue_valid_i, issue_op_i, issue_a_i, issue_b_i, issue_rob_i,
           issue_dest_i, issue_wren_i, wb_ready_i,
    output issue_ready_o, wb_valid_o, wb_result_o, wb_rob_o, wb_dest_o,
           wb_wren_o, wb_illegal_o
  );

  modport master (
    output issue_valid_i, issue_op_i, issue_a_i, issue_b_i, issue_rob_i,
           issue_dest_i, issue_wren_i, wb_ready_i,
    input  issue_ready_o, wb_valid_o, wb_result_o, wb_rob_o, wb_dest_o,
           wb_wren_o, wb_illegal_o
  );
endinterface

// File: rtl/bitmanip_exec_pipe_gates.sv
// Combinational logic/bitmanip unit. Unassigned op codes yield zero.
module gates
  import bmu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [5:0] cnt;

  // Evaluate the selected operation; counts are at most 32 so fit in 6 bits.
  always_comb begin
    result = '0;
    cnt    = 6'd0;
    case (op)
      BMU_AND:  result = a & b;
      BMU_OR:   result = a | b;
      BMU_XOR:  result = a ^ b;
      BMU_ORCB: begin
        for (int i = 0; i < 4; i++) result[i*8 +: 8] = {8{|a[i*8 +: 8]}};
      end
      BMU_ANDN: result = a & ~b;
      BMU_ORN:  result = a | ~b;
      BMU_XNOR: result = ~(a ^ b);
      BMU_CTZ: begin
        cnt = 6'd32;
        for (int i = 31; i >= 0; i--) if (a[i]) cnt = 6'(i);
        result = {26'd0, cnt};
      end
      BMU_REV8: result = {a[7:0], a[15:8], a[23:16], a[31:24]};
      BMU_CPOP: begin
        for (int i = 0; i < 32; i++) if (a[i]) cnt = cnt + 6'd1;
        result = {26'd0, cnt};
      end
      BMU_CLZ: begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++) if (a[i]) cnt = 6'(31 - i);
        result = {26'd0, cnt};
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/bitmanip_exec_pipe.sv
// Two-stage execution pipe around the gates unit: S1 registers the issued
// operands, S2 registers the result with its ROB tag for writeback.
// The struct widths come from bmu_pkg; ROB_W/PRF_W must match them.
module bitmanip_exec_pipe
  import bmu_pkg::*;
#(
  parameter int ROB_W = BMU_ROB_W,
  parameter int PRF_W = BMU_PRF_W
) (
  input  logic                 cpu_clock_i,
  input  logic                 cpu_resetn_i,
  input  logic                 flush_i,
  bitmanip_exec_pipe_if.slave  bus,
  output logic                 busy_o
);

  bmu_s1_t     s1_q;
  bmu_s2_t     s2_q;
  logic        s1_valid;
  logic        s2_valid;
  logic        s2_free;
  logic        s1_accept;
  logic        s2_load;
  logic        s1_legal;
  logic [31:0] gates_result;

  // S2 can take a new op when empty or when its op leaves this cycle.
  assign s2_free           = !s2_valid || bus.wb_ready_i;
  assign bus.issue_ready_o = !flush_i && (!s1_valid || s2_free);
  assign s1_accept         = bus.issue_valid_i && bus.issue_ready_o;
  assign s2_load           = s1_valid && s2_free;
  assign s1_legal          = bmu_op_legal(s1_q.op);

  gates u_gates (
    .op     (s1_q.op),
    .a      (s1_q.a),
    .b      (s1_q.b),
    .result (gates_result)
  );

  // Stage occupancy; flush drops both stages whatever the handshakes say.
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_accept)    s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (s2_load)                 s2_valid <= 1'b1;
      else if (bus.wb_ready_i)     s2_valid <= 1'b0;
    end
  end

  // Stage payloads; an illegal op carries a zero result and the flag.
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (s1_accept) begin
        s1_q.op   <= bus.issue_op_i;
        s1_q.a    <= bus.issue_a_i;
        s1_q.b    <= bus.issue_b_i;
        s1_q.rob  <= bus.issue_rob_i;
        s1_q.dest <= bus.issue_dest_i;
        s1_q.wren <= bus.issue_wren_i;
      end
      if (s2_load) begin
        s2_q.result  <= s1_legal ? gates_result : 32'd0;
        s2_q.rob     <= s1_q.rob;
        s2_q.dest    <= s1_q.dest;
        s2_q.wren    <= s1_q.wren;
        s2_q.illegal <= !s1_legal;
      end
    end
  end

  assign bus.wb_valid_o   = s2_valid;
  assign bus.wb_result_o  = s2_q.result;
  assign bus.wb_rob_o     = s2_q.rob[ROB_W-1:0];
  assign bus.wb_dest_o    = s2_q.dest[PRF_W-1:0];
  assign bus.wb_wren_o    = s2_q.wren;
  assign bus.wb_illegal_o = s2_q.illegal;
  assign busy_o           = s1_valid || s2_valid;

endmodule

// File: tb/tb_bitmanip_exec_pipe.sv
// Directed bench for bitmanip_exec_pipe with an in-order queue model of
// the in-flight ops checked every cycle, plus literal checks of results.
module tb_bitmanip_exec_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  bitmanip_exec_pipe_if bus ();

  bitmanip_exec_pipe dut (
    .cpu_clock_i  (clk),
    .cpu_resetn_i (rst_n),
    .flush_i      (flush),
    .bus          (bus),
    .busy_o       (busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  rob;
    logic [5:0]  dest;
    logic        wren;
    int          age;
  } mop_t;

  mop_t        mq[$];
  logic [31:0] log_res[$];
  logic        log_ill[$];
  logic [5:0]  log_rob[$];
  int          log_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_illegal(input logic [3:0] op);
    return op inside {4'd7, 4'd9, 4'd13, 4'd14, 4'd15};
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    int n;
    r = 32'd0;
    n = 0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a ^ b;
      4'd3:  for (int k = 0; k < 4; k++) r[8*k +: 8] = (((a >> (8*k)) & 32'hFF) != 0) ? 8'hFF : 8'h00;
      4'd4:  r = a & ~b;
      4'd5:  r = a | ~b;
      4'd6:  r = ~(a ^ b);
      4'd8:  begin while (n < 32 && !a[n]) n++; r = n; end
      4'd10: for (int k = 0; k < 4; k++) r[8*k +: 8] = a[8*(3-k) +: 8];
      4'd11: r = $countones(a);
      4'd12: begin while (n < 32 && !a[31-n]) n++; r = n; end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model: ordered list of accepted ops with the number of edges each has seen.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      bit acc;
      acc = bus.issue_valid_i && (mq.size() < 2 || bus.wb_ready_i);
      if (mq.size() > 0 && mq[0].age >= 1 && bus.wb_ready_i) void'(mq.pop_front());
      foreach (mq[i]) mq[i].age++;
      if (acc) mq.push_back('{op: bus.issue_op_i, a: bus.issue_a_i, b: bus.issue_b_i,
                              rob: bus.issue_rob_i, dest: bus.issue_dest_i,
                              wren: bus.issue_wren_i, age: 0});
    end
  end

  // Compare DUT against the model every cycle out of reset.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      bit ev;
      ev = mq.size() > 0 && mq[0].age >= 1;
      check("busy", busy, mq.size() != 0);
      check("wb_valid", bus.wb_valid_o, ev);
      check("issue_ready", bus.issue_ready_o, !flush && (mq.size() < 2 || bus.wb_ready_i));
      if (ev) begin
        check("wb_result", bus.wb_result_o,
              ref_illegal(mq[0].op) ? 32'd0 : ref_result(mq[0].op, mq[0].a, mq[0].b));
        check("wb_rob", bus.wb_rob_o, mq[0].rob);
        check("wb_dest", bus.wb_dest_o, mq[0].dest);
        check("wb_wren", bus.wb_wren_o, mq[0].wren);
        check("wb_illegal", bus.wb_illegal_o, ref_illegal(mq[0].op));
      end
    end
  end

  // Record every completed writeback handshake.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.wb_valid_o && bus.wb_ready_i) begin
      log_res.push_back(bus.wb_result_o);
      log_ill.push_back(bus.wb_illegal_o);
      log_rob.push_back(bus.wb_rob_o);
      log_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    log_res.delete();
    log_ill.delete();
    log_rob.delete();
    log_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_payload(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [5:0] rob);
    bus.issue_op_i   = op;
    bus.issue_a_i    = a;
    bus.issue_b_i    = b;
    bus.issue_rob_i  = rob;
    bus.issue_dest_i = ~rob;
    bus.issue_wren_i = rob[0];
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] rob);
    bit done;
    done = 1'b0;
    set_payload(op, a, b, rob);
    bus.issue_valid_i = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      done = bus.issue_ready_o;
      @(posedge clk);
      #1;
    end
    bus.issue_valid_i = 1'b0;
    if (!done) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_entry(input int idx, input string name, input logic [31:0] res,
                             input logic ill, input logic [5:0] rob);
    if (idx < log_res.size()) begin
      check({name, "_result"}, log_res[idx], res);
      check({name, "_illegal"}, log_ill[idx], ill);
      check({name, "_rob"}, log_rob[idx], rob);
    end else begin
      check({name, "_missing"}, log_res.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.issue_valid_i = 1'b0;
    bus.wb_ready_i    = 1'b0;
    set_payload(4'd0, 32'd0, 32'd0, 6'd0);

    #2;
    check("rst_wb_valid", bus.wb_valid_o, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_wb_result", bus.wb_result_o, 32'd0);
    check("rst_wb_illegal", bus.wb_illegal_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.issue_ready_o, 32'd1);
    idle(1);

    // Single AND with two-cycle latency.
    bus.wb_ready_i = 1'b1;
    clear_log();
    issue(4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 6'd5);
    @(negedge clk);
    check("t1_not_yet_valid", bus.wb_valid_o, 32'd0);
    @(negedge clk);
    check("t1_valid", bus.wb_valid_o, 32'd1);
    check("t1_result", bus.wb_result_o, 32'h00F0_000F);
    check("t1_rob", bus.wb_rob_o, 32'd5);
    check("t1_illegal", bus.wb_illegal_o, 32'd0);
    idle(3);

    // Back-to-back cpop, clz, rev8.
    clear_log();
    issue(4'b1011, 32'hFFFF_FFFF, 32'd0, 6'd1);
    issue(4'b1100, 32'h0001_0000, 32'd0, 6'd2);
    issue(4'b1010, 32'h1122_3344, 32'd0, 6'd3);
    idle(5);
    check("t2_count", log_res.size(), 32'd3);
    check_entry(0, "t2_cpop", 32'd32, 1'b0, 6'd1);
    check_entry(1, "t2_clz", 32'd15, 1'b0, 6'd2);
    check_entry(2, "t2_rev8", 32'h4433_2211, 1'b0, 6'd3);
    if (log_cyc.size() == 3) begin
      check("t2_consecutive_1", log_cyc[1], log_cyc[0] + 1);
      check("t2_consecutive_2", log_cyc[2], log_cyc[1] + 1);
    end

    // Stall: two accepted, third waits, drains in order on release.
    bus.wb_ready_i = 1'b0;
    clear_log();
    issue(4'b0010, 32'h0000_FFFF, 32'h00FF_00FF, 6'd10);
    issue(4'b0101, 32'h0000_0000, 32'hFFFF_0000, 6'd11);
    set_payload(4'b1000, 32'h0000_0100, 32'd0, 6'd12);
    bus.issue_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_stall_ready", bus.issue_ready_o, 32'd0);
      check("t3_stall_valid", bus.wb_valid_o, 32'd1);
      check("t3_stall_result", bus.wb_result_o, 32'h00FF_FF00);
      check("t3_stall_rob", bus.wb_rob_o, 32'd10);
      @(posedge clk);
      #1;
    end
    bus.wb_ready_i = 1'b1;
    @(negedge clk);
    check("t3_release_ready", bus.issue_ready_o, 32'd1);
    @(posedge clk);
    #1 bus.issue_valid_i = 1'b0;
    idle(5);
    check("t3_count", log_res.size(), 32'd3);
    check_entry(0, "t3_xor", 32'h00FF_FF00, 1'b0, 6'd10);
    check_entry(1, "t3_orn", 32'h0000_FFFF, 1'b0, 6'd11);
    check_entry(2, "t3_ctz", 32'd8, 1'b0, 6'd12);

    // Illegal op still retires, flagged with zero result.
    clear_log();
    issue(4'b1001, 32'hFFFF_FFFF, 32'h1234_5678, 6'd9);
    idle(4);
    check("t4_count", log_res.size(), 32'd1);
    check_entry(0, "t4_illegal", 32'd0, 1'b1, 6'd9);

    // Flush with both stages full and a same-cycle issue.
    bus.wb_ready_i = 1'b0;
    clear_log();
    issue(4'b0001, 32'h0000_00F0, 32'h0000_000F, 6'd20);
    issue(4'b0110, 32'hAAAA_AAAA, 32'h5555_5555, 6'd21);
    @(negedge clk);
    check("t5_full_busy", busy, 32'd1);
    @(posedge clk);
    #1;
    set_payload(4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd22);
    bus.issue_valid_i = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("t5_flush_ready", bus.issue_ready_o, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.issue_valid_i = 1'b0;
    @(negedge clk);
    check("t5_post_valid", bus.wb_valid_o, 32'd0);
    check("t5_post_busy", busy, 32'd0);
    bus.wb_ready_i = 1'b1;
    idle(4);
    check("t5_nothing_retired", log_res.size(), 32'd0);

    // Asynchronous reset mid-stream.
    bus.wb_ready_i = 1'b0;
    issue(4'b0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 6'd30);
    issue(4'b0011, 32'h0100_0001, 32'd0, 6'd31);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", bus.wb_valid_o, 32'd0);
    check("t6_async_busy", busy, 32'd0);
    check("t6_async_result", bus.wb_result_o, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.wb_ready_i = 1'b1;
    clear_log();
    issue(4'b0011, 32'h0100_0001, 32'd0, 6'd33);
    idle(4);
    check("t6_count", log_res.size(), 32'd1);
    check_entry(0, "t6_orcb", 32'hFF00_00FF, 1'b0, 6'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
